// File: rtl/aes_block_packer_pkg.sv
// Shared AES types and block-packer constants.
// Imported by the packer and its handshake interface.
package aes_block_packer_pkg;

    typedef logic [127:0] aes_data_t;
    typedef logic [127:0] aes_key_t;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/aes_block_packer_if.sv
// Byte-in / block-out handshake bundle of the AES block packer.
// master is the packer side, slave is the producer/consumer side.
interface aes_block_packer_if;
    import aes_block_packer_pkg::*;

    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    aes_data_t  o_data;
    logic [4:0] o_len;
    logic       o_last;
    logic       o_valid;
    logic       o_ready;

    modport master (
        input  in_byte,
        input  in_valid,
        input  in_last,
        output in_ready,
        output o_data,
        output o_len,
        output o_last,
        output o_valid,
        input  o_ready
    );

    modport slave (
        output in_byte,
        output in_valid,
        output in_last,
        input  in_ready,
        input  o_data,
        input  o_len,
        input  o_last,
        input  o_valid,
        output o_ready
    );

endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream into zero-padded 128-bit AES blocks.
// Accumulator plus output register keep one byte per cycle flowing.
module aes_block_packer
    import aes_block_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    aes_block_packer_if.master    bus
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    aes_data_t  acc;
    logic [4:0] acc_len;
    logic       acc_last;

    aes_data_t  out_data;
    logic [4:0] out_len;
    logic       out_last;
    logic       out_valid;

    logic       accept;
    logic       complete;
    logic       slot_free;
    logic       load_direct;
    logic       load_hold;
    aes_data_t  merged;

    assign bus.in_ready = (state == FILL);
    assign bus.o_data   = out_data;
    assign bus.o_len    = out_len;
    assign bus.o_last   = out_last;
    assign bus.o_valid  = out_valid;

    // First byte of a block lands in the top byte lane.
    assign accept    = bus.in_valid && (state == FILL);
    assign complete  = accept && ((cnt == 4'd15) || bus.in_last);
    assign slot_free = !out_valid || bus.o_ready;
    assign merged    = acc
                     | ({120'b0, bus.in_byte} << {4'd15 - cnt, 3'b000});

    always_comb begin
        state_nxt   = state;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        unique case (state)
            FILL: begin
                if (complete) begin
                    if (slot_free) begin
                        load_direct = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.o_ready && out_valid) begin
                    load_hold = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator is wiped at every block hand-off so padding stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 4'd0;
            acc      <= '0;
            acc_len  <= 5'd0;
            acc_last <= 1'b0;
        end else if (load_direct || load_hold) begin
            cnt      <= 4'd0;
            acc      <= '0;
            acc_len  <= 5'd0;
            acc_last <= 1'b0;
        end else if (complete) begin
            acc      <= merged;
            acc_len  <= {1'b0, cnt} + 5'd1;
            acc_last <= bus.in_last;
        end else if (accept) begin
            acc <= merged;
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_len   <= 5'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_direct) begin
            out_data  <= merged;
            out_len   <= {1'b0, cnt} + 5'd1;
            out_last  <= bus.in_last;
            out_valid <= 1'b1;
        end else if (load_hold) begin
            out_data  <= acc;
            out_len   <= acc_len;
            out_last  <= acc_last;
            out_valid <= 1'b1;
        end else if (bus.o_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed, table-driven bench for the AES block packer.
// Inputs change 1 time unit after the rising edge.
module tb_aes_block_packer;
    import aes_block_packer_pkg::*;

    typedef struct {
        logic [127:0] msg;
        int           n;
        logic         last;
        logic [127:0] exp_data;
        logic [4:0]   exp_len;
        logic         exp_last;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_block_packer_if bus();

    aes_block_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        int bud;
        bus.in_byte  = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        bud = 100;
        while (!bus.in_ready && bud > 0) begin
            step();
            bud--;
        end
        if (bud == 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 expected 1");
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_blk(input string name,
                           input logic [127:0] d,
                           input logic [4:0] l,
                           input logic last);
        chk({name, "_valid"}, 128'(bus.o_valid), 128'(1'b1));
        chk({name, "_data"}, bus.o_data, d);
        chk({name, "_len"}, 128'(bus.o_len), 128'(l));
        chk({name, "_last"}, 128'(bus.o_last), 128'(last));
    endtask

    vec_t vecs[5];
    logic [127:0] sblk[3];

    initial begin
        checks = 0;
        errors = 0;
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.o_ready  = 1'b0;
        rst = 1'b0;

        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 16, 1'b1,
                    128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b1};
        vecs[1] = '{128'hAABBCC00_00000000_00000000_00000000, 3, 1'b1,
                    128'hAABBCC00_00000000_00000000_00000000, 5'd3, 1'b1};
        vecs[2] = '{128'h101112131415161718191A1B1C1D1E1F, 16, 1'b0,
                    128'h101112131415161718191A1B1C1D1E1F, 5'd16, 1'b0};
        vecs[3] = '{128'h55000000_00000000_00000000_00000000, 1, 1'b1,
                    128'h55000000_00000000_00000000_00000000, 5'd1, 1'b1};
        vecs[4] = '{128'hF0F1F2F3_F4F5F6F7_00000000_00000000, 8, 1'b1,
                    128'hF0F1F2F3_F4F5F6F7_00000000_00000000, 5'd8, 1'b1};
        sblk[0] = 128'h404142434445464748494A4B4C4D4E4F;
        sblk[1] = 128'h505152535455565758595A5B5C5D5E5F;
        sblk[2] = 128'h606162636465666768696A6B6C6D6E6F;

        #12;
        chk("rst_valid", 128'(bus.o_valid), 128'(1'b0));
        chk("rst_data", bus.o_data, 128'h0);
        chk("rst_len", 128'(bus.o_len), 128'h0);
        chk("rst_last", 128'(bus.o_last), 128'h0);
        rst = 1'b1;
        step();
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));

        // table: one message per record, consumer always ready
        bus.o_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                push(vecs[v].msg[127 - 8*i -: 8],
                     vecs[v].last && (i == vecs[v].n - 1));
            end
            chk_blk($sformatf("vec%0d", v), vecs[v].exp_data,
                    vecs[v].exp_len, vecs[v].exp_last);
            step();
            chk($sformatf("vec%0d_drain", v), 128'(bus.o_valid), 128'(1'b0));
        end

        // backpressure: two blocks, consumer stalled
        bus.o_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push(8'(8'h20 + i), i == 31);
            if (i == 15) begin
                chk_blk("bp_b1", 128'h202122232425262728292A2B2C2D2E2F,
                        5'd16, 1'b0);
            end
        end
        chk("bp_hold_ready", 128'(bus.in_ready), 128'(1'b0));
        step();
        chk("bp_hold_stable", bus.o_data,
            128'h202122232425262728292A2B2C2D2E2F);
        chk("bp_hold_still", 128'(bus.in_ready), 128'(1'b0));
        bus.o_ready = 1'b1;
        step();
        bus.o_ready = 1'b0;
        chk_blk("bp_b2", 128'h303132333435363738393A3B3C3D3E3F,
                5'd16, 1'b1);
        chk("bp_ready_back", 128'(bus.in_ready), 128'(1'b1));
        bus.o_ready = 1'b1;
        step();
        chk("bp_drain", 128'(bus.o_valid), 128'(1'b0));

        // continuous stream of three blocks
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) begin
                push(8'(8'h40 + 16*b + i), (b == 2) && (i == 15));
            end
            chk_blk($sformatf("str%0d", b), sblk[b], 5'd16, b == 2);
        end
        step();
        chk("str_no_dup", 128'(bus.o_valid), 128'(1'b0));

        push(8'h55, 1'b1);
        chk_blk("single", 128'h55000000_00000000_00000000_00000000,
                5'd1, 1'b1);
        step();

        // async reset with a pending block and a partial one
        bus.o_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            push(8'(8'h70 + i), 1'b0);
        end
        chk("pre_rst_valid", 128'(bus.o_valid), 128'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.o_valid), 128'(1'b0));
        chk("mid_rst_data", bus.o_data, 128'h0);
        #2;
        rst = 1'b1;
        step();
        bus.o_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h80 + i), 1'b0);
        end
        chk_blk("post_rst", 128'h808182838485868788898A8B8C8D8E8F,
                5'd16, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
